fir_result_collector: RTL and testbench

Downstream stage of the FIR filter. Captures each valid filter result, rounds and scales it, then narrows it to the bus width, either by saturation or by truncation. Results are buffered in a show-ahead FIFO for the APB accelerator wrapper to read. It counts results against the programmed output length and flags completion, FIFO overflow and early pipeline flush (underrun) to the wrapper.

---
 rtl/fir_collect_pkg.sv | 6 +
 rtl/fir_result_fifo.sv | 41 ++++
 rtl/fir_result_collector.sv | 107 ++++++++++
 tb/tb_fir_result_collector.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_collect_pkg.sv
// fir_collect_pkg: collector FSM state type and control-field widths shared by the collector files.
package fir_collect_pkg;
    localparam int LEN_W   = 16;
    localparam int SHIFT_W = 5;
    typedef enum logic [1:0] {IDLE, COLLECT, LAST, DONE} state_t;
endpackage

// File: rtl/fir_result_fifo.sv
// fir_result_fifo: synchronous show-ahead FIFO with sync clear; only the pointers are reset.
module fir_result_fifo #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic          w_push_ok, w_pop_ok;
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = o_count == (AW+1)'(DEPTH);
    assign o_empty   = o_count == '0;
    assign w_pop_ok  = i_pop & ~o_empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    always_ff @(posedge i_clk)
        if (w_push_ok & ~i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
endmodule

// File: rtl/fir_result_collector.sv
// fir_result_collector: rounds/scales FIR results, narrows them to DW and buffers them for the bus.
// Define FIR_COLLECT_SAT_EN to clamp on narrowing; otherwise the low DW bits are kept (wrap).
module fir_result_collector
    import fir_collect_pkg::*;
#(
    parameter  int IW    = 31,
    parameter  int DW    = 16,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_output_length,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic [IW-1:0]      i_result,
    input  logic               i_valid_result,
    input  logic               i_clean_pip,
    input  logic               i_rd_en,
    output logic [DW-1:0]      o_rd_data,
    output logic               o_empty,
    output logic               o_full,
    output logic [CW-1:0]      o_count,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic               o_underrun
);
    state_t              r_state, w_next;
    logic [LEN_W-1:0]    r_remaining;
    logic [SHIFT_W-1:0]  r_shift;
    logic [DW-1:0]       r_stage;
    logic                r_stage_vld, r_overflow, r_underrun, r_clean_d;
    logic                w_accept, w_last_acc, w_under, w_drop;
    logic signed [IW:0]  w_round, w_sum;
    logic [DW-1:0]       w_narrow;
    assign w_accept   = (r_state == COLLECT) & i_valid_result & ~i_start;
    assign w_last_acc = w_accept & (r_remaining == LEN_W'(1));
    assign w_under    = (r_state == COLLECT) & ~i_start & r_clean_d & ~i_clean_pip & ~w_last_acc;
    assign w_drop     = r_stage_vld & ~i_start & o_full & ~i_rd_en;
    assign w_round    = (r_shift == '0) ? '0 : (IW+1)'(1) << (r_shift - 1'b1);
    assign w_sum      = $signed({i_result[IW-1], i_result}) + w_round;
`ifdef FIR_COLLECT_SAT_EN
    logic signed [IW:0] w_scaled;
    logic               w_sat;
    assign w_scaled = w_sum >>> r_shift;
    // out of range when the bits above the DW sign bit are not a pure sign extension
    assign w_sat    = ~(&w_scaled[IW:DW-1] | ~|w_scaled[IW:DW-1]);
    assign w_narrow = w_sat ? (w_scaled[IW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                            : w_scaled[DW-1:0];
`else
    assign w_narrow = DW'(w_sum >>> r_shift);
`endif
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (i_start) w_next = (i_output_length == '0) ? DONE : COLLECT;
        else if (r_state == LAST) w_next = DONE;
        else if (w_last_acc | w_under) w_next = w_last_acc ? LAST : DONE;
    end
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            r_remaining <= '0;
            r_shift     <= '0;
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
            r_overflow  <= 1'b0;
            r_underrun  <= 1'b0;
            r_clean_d   <= 1'b0;
        end else begin
            r_clean_d <= i_clean_pip;
            if (i_start) begin
                r_remaining <= i_output_length;
                r_shift     <= i_shift;
                r_stage     <= '0;
                r_stage_vld <= 1'b0;
                r_overflow  <= 1'b0;
                r_underrun  <= 1'b0;
            end else begin
                r_stage_vld <= w_accept;
                if (w_accept) begin
                    r_stage     <= w_narrow;
                    r_remaining <= r_remaining - 1'b1;
                end
                if (w_drop) r_overflow <= 1'b1;
                if (w_under) r_underrun <= 1'b1;
            end
        end
    fir_result_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_start),
        .i_push    (r_stage_vld),
        .i_data    (r_stage),
        .i_pop     (i_rd_en),
        .o_data    (o_rd_data),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_count   (o_count)
    );
    assign o_busy     = (r_state == COLLECT) | (r_state == LAST);
    assign o_done     = r_state == DONE;
    assign o_overflow = r_overflow;
    assign o_underrun = r_underrun;
endmodule

// File: tb/tb_fir_result_collector.sv
// tb_fir_result_collector: directed scoreboard bench for fir_result_collector (honours FIR_COLLECT_SAT_EN).
module tb_fir_result_collector;
    logic        i_clk = 1'b0, i_reset_n = 1'b0, i_start = 1'b0;
    logic [15:0] i_output_length = '0;
    logic [4:0]  i_shift = '0;
    logic [30:0] i_result = '0;
    logic        i_valid_result = 1'b0, i_clean_pip = 1'b0, i_rd_en = 1'b0;
    logic [15:0] o_rd_data;
    logic        o_empty, o_full, o_busy, o_done, o_overflow, o_underrun;
    logic [4:0]  o_count;
    int          checks = 0, failures = 0, cur_shift = 0;
    logic [15:0] q[$];

    fir_result_collector dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_output_length(i_output_length), .i_shift(i_shift), .i_result(i_result),
        .i_valid_result(i_valid_result), .i_clean_pip(i_clean_pip), .i_rd_en(i_rd_en),
        .o_rd_data(o_rd_data), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow), .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] model(input logic signed [30:0] r, input int sh);
        longint v = r;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
`ifdef FIR_COLLECT_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int len, input int sh);
        i_start = 1'b1;
        i_output_length = 16'(len);
        i_shift = 5'(sh);
        cur_shift = sh;
        tick;
        i_start = 1'b0;
    endtask

    task automatic send(input int val, input bit exp_push);
        i_valid_result = 1'b1;
        i_result = 31'(val);
        if (exp_push) q.push_back(model(31'(val), cur_shift));
        tick;
        i_valid_result = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        chk({tag, "_nonempty"}, o_empty, 0);
        chk({tag, "_sb_has_entry"}, q.size() > 0, 1);
        e = (q.size() > 0) ? q.pop_front() : 16'h0;
        chk(tag, o_rd_data, e);
        i_rd_en = 1'b1;
        tick;
        i_rd_en = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_empty", o_empty, 1);
        chk("rst_count", o_count, 0);
        chk("rst_flags", {o_full, o_busy, o_done, o_overflow, o_underrun}, 0);
        chk("rst_data", o_rd_data, 0);
        i_reset_n = 1'b1;
        tick;

        // rounding and scaling, done two cycles after the last valid
        start(3, 4);
        chk("t1_busy", o_busy, 1);
        send(24, 1);
        send(-24, 1);
        send(7, 1);
        chk("t1_done_early", o_done, 0);
        tick;
        chk("t1_done", o_done, 1);
        chk("t1_count", o_count, 3);
        chk("t1_head_const", o_rd_data, 16'h0002);
        for (int k = 0; k < 3; k++) pop_chk($sformatf("t1_pop%0d", k));
        chk("t1_drained", o_empty, 1);
        send(100, 0);
        tick;
        chk("t1_ignore_done", o_count, 0);

        // narrowing of out-of-range values
        start(2, 0);
        send(40000, 1);
        send(-40000, 1);
        tick;
`ifdef FIR_COLLECT_SAT_EN
        chk("sat_pos_const", o_rd_data, 16'h7FFF);
`else
        chk("wrap_pos_const", o_rd_data, 16'h9C40);
`endif
        pop_chk("sat_pos");
`ifdef FIR_COLLECT_SAT_EN
        chk("sat_neg_const", o_rd_data, 16'h8000);
`else
        chk("wrap_neg_const", o_rd_data, 16'h63C0);
`endif
        pop_chk("sat_neg");

        // fill to full, push+pop while full, then drop on full
        start(20, 0);
        for (int k = 0; k < 16; k++) send(k * 3 + 1, 1);
        tick;
        chk("ov_count16", o_count, 16);
        chk("ov_full", o_full, 1);
        chk("ov_not_yet", o_overflow, 0);
        chk("ov_head_first", o_rd_data, 16'd1);
        i_valid_result = 1'b1;
        i_result = 31'(16 * 3 + 1);
        q.push_back(model(31'(16 * 3 + 1), 0));
        tick;
        i_valid_result = 1'b0;
        i_rd_en = 1'b1;
        void'(q.pop_front());
        tick;
        i_rd_en = 1'b0;
        chk("ov_pushpop_count", o_count, 16);
        chk("ov_pushpop_noflag", o_overflow, 0);
        chk("ov_head_second", o_rd_data, 16'd4);
        for (int k = 17; k < 20; k++) send(k * 3 + 1, 0);
        tick;
        chk("ov_flag", o_overflow, 1);
        chk("ov_done", o_done, 1);
        chk("ov_count_final", o_count, 16);
        for (int k = 0; k < 16; k++) pop_chk($sformatf("ov_pop%0d", k));
        chk("ov_drained", o_empty, 1);

        // early flush ends the run
        i_clean_pip = 1'b1;
        start(10, 0);
        chk("ur_ov_cleared", o_overflow, 0);
        for (int k = 0; k < 6; k++) send(1000 - k * 7, 1);
        i_clean_pip = 1'b0;
        tick;
        chk("ur_flag", o_underrun, 1);
        chk("ur_done", o_done, 1);
        chk("ur_count", o_count, 6);
        for (int k = 0; k < 6; k++) pop_chk($sformatf("ur_pop%0d", k));

        // zero length
        start(0, 0);
        chk("len0_done", o_done, 1);
        chk("len0_empty", o_empty, 1);
        chk("len0_ur_cleared", o_underrun, 0);
        chk("len0_busy", o_busy, 0);

        // restart in the middle of a run
        start(8, 2);
        for (int k = 0; k < 5; k++) send(k * 11 - 20, 0);
        start(4, 2);
        chk("rs_empty", o_empty, 1);
        chk("rs_count", o_count, 0);
        chk("rs_flags", {o_done, o_overflow, o_underrun}, 0);
        chk("rs_busy", o_busy, 1);
        for (int k = 0; k < 4; k++) send(-(k * 13) + 5, 1);
        tick;
        chk("rs_done", o_done, 1);
        chk("rs_count4", o_count, 4);
        for (int k = 0; k < 4; k++) pop_chk($sformatf("rs_pop%0d", k));

        // asynchronous reset between clock edges
        start(10, 0);
        for (int k = 0; k < 3; k++) send(k + 50, 0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("ar_empty", o_empty, 1);
        chk("ar_count", o_count, 0);
        chk("ar_flags", {o_full, o_busy, o_done, o_overflow, o_underrun}, 0);
        chk("ar_data", o_rd_data, 0);
        #2;
        i_reset_n = 1'b1;
        tick;
        chk("ar_idle", {o_busy, o_done}, 0);
        chk("ar_still_empty", o_empty, 1);
        q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
